// File: rtl/lvds_acq_sched.sv
// rtl/lvds_acq_sched.sv - LVDS acquisition sequencer: TX trigger, settle, capture window, per-channel drain
// Optional feature: define LVDS_ACQ_TIMEOUT_EN to add a 256-cycle rd_ack timeout that sets err and skips the channel.
module lvds_acq_sched #(
   parameter int NCH      = 10,
   parameter int SETTLE_W = 16,
   parameter int LEN_W    = 8
) (
   input  logic                lvds_clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [NCH-1:0]      ch_mask,
   input  logic [SETTLE_W-1:0] settle_cyc,
   input  logic [LEN_W-1:0]    cap_len,
   input  logic [LEN_W-1:0]    words_per_ch,
   input  logic                rd_ack,
   output logic                tx_flag,
   output logic [NCH-1:0]      cap_en,
   output logic [NCH-1:0]      rd_req,
   output logic [3:0]          cur_ch,
   output logic                busy,
   output logic                done,
   output logic                err
);

   // One phase counter serves both SETTLE and CAPTURE, so it must fit the wider field.
   localparam int CW = (SETTLE_W > LEN_W) ? SETTLE_W : LEN_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX,
      S_SETTLE,
      S_CAPTURE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t              state;
   state_t              state_nx;

   // Configuration snapshot taken on the accepted start.
   logic [NCH-1:0]      mask_q;
   logic [SETTLE_W-1:0] settle_q;
   logic [LEN_W-1:0]    cap_len_q;
   logic [LEN_W-1:0]    wpc_q;

   logic [CW-1:0]       cnt;
   logic [LEN_W-1:0]    word_cnt;
   logic [3:0]          ch_q;
   logic                gap_q;
   logic                done_q;

   logic                accept;
   logic                settle_end;
   logic                cap_end;
   logic                req_on;
   logic                word_last;
   logic                tmo_hit;
   logic                ch_finish;
   logic [3:0]          first_ch;
   logic [3:0]          next_ch;
   logic                has_next;

   assign accept     = (state == S_IDLE) && start && !abort;
   assign settle_end = (cnt + CW'(1)) >= CW'(settle_q);
   // A zero capture length still yields one capture cycle because cnt+1 >= 0 always holds.
   assign cap_end    = (cnt + CW'(1)) >= CW'(cap_len_q);
   assign req_on     = (state == S_DRAIN) && !gap_q;
   assign word_last  = req_on && rd_ack && ((word_cnt + LEN_W'(1)) == wpc_q);
   assign ch_finish  = word_last || tmo_hit;
   assign cur_ch     = ch_q;
   assign done       = done_q;

   // Find the lowest enabled channel and the lowest enabled channel above the one being drained.
   always_comb begin
      first_ch = '0;
      next_ch  = '0;
      has_next = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            first_ch = 4'(i);
            if (i > int'(ch_q)) begin
               next_ch  = 4'(i);
               has_next = 1'b1;
            end
         end
      end
   end

   // State register.
   always_ff @(posedge lvds_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode and state-derived outputs; abort overrides every transition.
   always_comb begin
      state_nx = state;
      tx_flag  = 1'b0;
      cap_en   = '0;
      rd_req   = '0;
      busy     = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = (ch_mask != '0) ? S_TX : S_DONE;
            end
         end
         S_TX: begin
            tx_flag  = 1'b1;
            state_nx = (settle_q != '0) ? S_SETTLE : S_CAPTURE;
         end
         S_SETTLE: begin
            if (settle_end) begin
               state_nx = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            cap_en = mask_q;
            if (cap_end) begin
               state_nx = (wpc_q != '0) ? S_DRAIN : S_DONE;
            end
         end
         S_DRAIN: begin
            if (req_on) begin
               rd_req = NCH'(1) << ch_q;
            end
            if (ch_finish && !has_next) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
      if (abort) begin
         state_nx = S_IDLE;
      end
   end

   // Configuration snapshot, phase counter, drain bookkeeping and the registered done pulse.
   always_ff @(posedge lvds_clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q    <= '0;
         settle_q  <= '0;
         cap_len_q <= '0;
         wpc_q     <= '0;
         cnt       <= '0;
         word_cnt  <= '0;
         ch_q      <= '0;
         gap_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         // done fires on the edge leaving DONE, unless that exit was an abort.
         done_q <= (state == S_DONE) && !abort;

         if (accept) begin
            mask_q    <= ch_mask;
            settle_q  <= settle_cyc;
            cap_len_q <= cap_len;
            wpc_q     <= words_per_ch;
         end

         if (state_nx != state) begin
            cnt <= '0;
         end else if ((state == S_SETTLE) || (state == S_CAPTURE)) begin
            cnt <= cnt + CW'(1);
         end

         if ((state == S_CAPTURE) && (state_nx == S_DRAIN)) begin
            ch_q     <= first_ch;
            word_cnt <= '0;
            gap_q    <= 1'b0;
         end else if (state == S_DRAIN) begin
            if (gap_q) begin
               gap_q <= 1'b0;
            end else if (ch_finish) begin
               word_cnt <= '0;
               if (has_next) begin
                  ch_q  <= next_ch;
                  gap_q <= 1'b1;
               end
            end else if (rd_ack) begin
               word_cnt <= word_cnt + LEN_W'(1);
            end
         end
      end
   end

`ifdef LVDS_ACQ_TIMEOUT_EN
   logic [7:0] tmo_cnt;
   logic       err_q;

   // The 256th consecutive unanswered request cycle gives up on the channel.
   assign tmo_hit = req_on && !rd_ack && (tmo_cnt == 8'hFF);
   assign err     = err_q;

   // Count request cycles without an ack; any ack, gap or abort restarts the count.
   always_ff @(posedge lvds_clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (!req_on || rd_ack || abort) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 8'd1;
      end
   end

   // Sticky timeout flag, cleared only by the next accepted start.
   always_ff @(posedge lvds_clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= 1'b0;
      end else if (tmo_hit) begin
         err_q <= 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_lvds_acq_sched.sv
// tb/tb_lvds_acq_sched.sv - self-checking bench for lvds_acq_sched against a timeline reference model
module tb_lvds_acq_sched;

   localparam int NCH  = 10;
   localparam int MAXT = 1024;

   logic              lvds_clk;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic [NCH-1:0]    ch_mask;
   logic [15:0]       settle_cyc;
   logic [7:0]        cap_len;
   logic [7:0]        words_per_ch;
   logic              rd_ack;
   logic              tx_flag;
   logic [NCH-1:0]    cap_en;
   logic [NCH-1:0]    rd_req;
   logic [3:0]        cur_ch;
   logic              busy;
   logic              done;
   logic              err;

   int checks;
   int failures;

   // Expected per-cycle outputs, index = cycles after the edge that sampled start.
   logic              e_tx   [MAXT];
   logic [NCH-1:0]    e_cap  [MAXT];
   logic [NCH-1:0]    e_req  [MAXT];
   logic [3:0]        e_ch   [MAXT];
   logic              e_done [MAXT];
   logic              e_busy [MAXT];
   logic              e_err  [MAXT];
   logic              ack_bits [MAXT];
   int                e_len;

   lvds_acq_sched #(.NCH(NCH), .SETTLE_W(16), .LEN_W(8)) dut (
      .lvds_clk     (lvds_clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .ch_mask      (ch_mask),
      .settle_cyc   (settle_cyc),
      .cap_len      (cap_len),
      .words_per_ch (words_per_ch),
      .rd_ack       (rd_ack),
      .tx_flag      (tx_flag),
      .cap_en       (cap_en),
      .rd_req       (rd_req),
      .cur_ch       (cur_ch),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   initial lvds_clk = 1'b0;
   always #5 lvds_clk = ~lvds_clk;

   // Timeline of one acquisition built directly from the sequencing rules.
   task automatic build_model(input logic [NCH-1:0] m, input int st, input int cl, input int wpc);
      int t;
      int nw;
      int waitc;
      int err_from;
      bit first;
      for (int i = 0; i < MAXT; i++) begin
         e_tx[i] = 1'b0; e_cap[i] = '0; e_req[i] = '0; e_ch[i] = '0;
         e_done[i] = 1'b0; e_busy[i] = 1'b0; e_err[i] = 1'b0;
      end
      t = 1; err_from = MAXT; first = 1'b1;
      if (m != '0) begin
         e_tx[t] = 1'b1; e_busy[t] = 1'b1; t++;
         for (int k = 0; k < st; k++) begin e_busy[t] = 1'b1; t++; end
         for (int k = 0; k < ((cl == 0) ? 1 : cl); k++) begin e_cap[t] = m; e_busy[t] = 1'b1; t++; end
         if (wpc != 0) begin
            for (int c = 0; c < NCH; c++) begin
               if (m[c]) begin
                  if (!first) begin e_busy[t] = 1'b1; t++; end
                  first = 1'b0; nw = 0; waitc = 0;
                  while (nw < wpc) begin
                     e_req[t] = NCH'(1) << c; e_ch[t] = 4'(c); e_busy[t] = 1'b1;
                     if (ack_bits[t]) begin nw++; waitc = 0; end else waitc++;
                     t++;
`ifdef LVDS_ACQ_TIMEOUT_EN
                     if (waitc == 256) begin
                        if (err_from == MAXT) err_from = t;
                        break;
                     end
`endif
                  end
               end
            end
         end
      end
      e_busy[t] = 1'b1;
      e_done[t+1] = 1'b1;
      e_len = t + 2;
      for (int k = err_from; k < e_len; k++) e_err[k] = 1'b1;
   endtask

   function automatic logic [27:0] obs_vec(input bit use_ch);
      return {tx_flag, cap_en, rd_req, done, busy, err, (use_ch ? cur_ch : 4'd0)};
   endfunction

   function automatic logic [27:0] exp_vec(input int t);
      return {e_tx[t], e_cap[t], e_req[t], e_done[t], e_busy[t], e_err[t],
              ((e_req[t] != '0) ? e_ch[t] : 4'd0)};
   endfunction

   task automatic test_reset();
      repeat (3) @(negedge lvds_clk);
      checks++;
      if (obs_vec(1'b1) !== 28'd0) begin
         failures++; $display("FAIL reset_hold got=%h exp=0", obs_vec(1'b1));
      end
      rst_n = 1'b1;
      @(negedge lvds_clk);
      checks++;
      if (obs_vec(1'b1) !== 28'd0) begin
         failures++; $display("FAIL reset_release got=%h exp=0", obs_vec(1'b1));
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < MAXT; i++) ack_bits[i] = 1'b1;
      build_model(10'h005, 3, 4, 2);
      @(negedge lvds_clk);
      ch_mask = 10'h005; settle_cyc = 16'd3; cap_len = 8'd4; words_per_ch = 8'd2; start = 1'b1;
      rd_ack = ack_bits[0];
      for (int t = 1; t < e_len; t++) begin
         @(negedge lvds_clk);
         start = 1'b0; rd_ack = ack_bits[t];
         checks++;
         if (obs_vec(e_req[t] != '0) !== exp_vec(t)) begin
            failures++; $display("FAIL basic t=%0d got=%h exp=%h", t, obs_vec(e_req[t] != '0), exp_vec(t));
         end
      end
      rd_ack = 1'b0;
   endtask

   task automatic test_zero_mask();
      for (int i = 0; i < MAXT; i++) ack_bits[i] = 1'b0;
      build_model('0, 5, 5, 5);
      @(negedge lvds_clk);
      ch_mask = '0; settle_cyc = 16'd5; cap_len = 8'd5; words_per_ch = 8'd5; start = 1'b1;
      for (int t = 1; t < e_len + 2; t++) begin
         @(negedge lvds_clk);
         start = 1'b0;
         checks++;
         if (obs_vec(1'b0) !== ((t < e_len) ? exp_vec(t) : 28'd0)) begin
            failures++; $display("FAIL zero_mask t=%0d got=%h exp=%h", t, obs_vec(1'b0),
                                 ((t < e_len) ? exp_vec(t) : 28'd0));
         end
      end
   endtask

   task automatic test_abort();
      int reqs;
      for (int i = 0; i < MAXT; i++) ack_bits[i] = ($urandom_range(0, 1) == 1);
      build_model(10'h0C4, 1, 1, 3);
      @(negedge lvds_clk);
      ch_mask = 10'h0C4; settle_cyc = 16'd1; cap_len = 8'd1; words_per_ch = 8'd3; start = 1'b1;
      reqs = 0;
      for (int t = 1; t < e_len; t++) begin
         @(negedge lvds_clk);
         start = 1'b0; rd_ack = ack_bits[t];
         checks++;
         if (obs_vec(e_req[t] != '0) !== exp_vec(t)) begin
            failures++; $display("FAIL abort_pre t=%0d got=%h exp=%h", t, obs_vec(e_req[t] != '0), exp_vec(t));
         end
         if (e_req[t] != '0) reqs++;
         if (reqs == 2) begin
            abort = 1'b1;
            break;
         end
      end
      @(negedge lvds_clk);
      rd_ack = 1'b0;
      checks++;
      if (obs_vec(1'b0) !== 28'd0) begin
         failures++; $display("FAIL abort_idle got=%h exp=0", obs_vec(1'b0));
      end
      start = 1'b1; ch_mask = 10'h3FF;
      @(negedge lvds_clk);
      start = 1'b0; abort = 1'b0;
      checks++;
      if (obs_vec(1'b0) !== 28'd0) begin
         failures++; $display("FAIL abort_beats_start got=%h exp=0", obs_vec(1'b0));
      end
      repeat (2) begin
         @(negedge lvds_clk);
         checks++;
         if (obs_vec(1'b0) !== 28'd0) begin
            failures++; $display("FAIL abort_quiet got=%h exp=0", obs_vec(1'b0));
         end
      end
      test_basic();
   endtask

   task automatic test_ignore();
      bit changed;
      for (int i = 0; i < MAXT; i++) ack_bits[i] = ($urandom_range(0, 2) != 0);
      build_model(10'h0A2, 5, 3, 1);
      @(negedge lvds_clk);
      ch_mask = 10'h0A2; settle_cyc = 16'd5; cap_len = 8'd3; words_per_ch = 8'd1; start = 1'b1;
      changed = 1'b0;
      for (int t = 1; t < e_len; t++) begin
         @(negedge lvds_clk);
         start = (t == 3); rd_ack = ack_bits[t];
         checks++;
         if (obs_vec(e_req[t] != '0) !== exp_vec(t)) begin
            failures++; $display("FAIL ignore t=%0d got=%h exp=%h", t, obs_vec(e_req[t] != '0), exp_vec(t));
         end
         if ((e_cap[t] != '0) && !changed) begin
            changed = 1'b1;
            ch_mask = 10'h35D; settle_cyc = 16'd0; cap_len = 8'd1; words_per_ch = 8'd5;
         end
      end
      rd_ack = 1'b0;
      repeat (3) begin
         @(negedge lvds_clk);
         checks++;
         if (obs_vec(1'b0) !== 28'd0) begin
            failures++; $display("FAIL ignore_after got=%h exp=0", obs_vec(1'b0));
         end
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < MAXT; i++) ack_bits[i] = (i >= 400);
      build_model(10'h200, 0, 1, 1);
      @(negedge lvds_clk);
      ch_mask = 10'h200; settle_cyc = 16'd0; cap_len = 8'd1; words_per_ch = 8'd1; start = 1'b1;
      for (int t = 1; t < e_len; t++) begin
         @(negedge lvds_clk);
         start = 1'b0; rd_ack = ack_bits[t];
         checks++;
         if (obs_vec(e_req[t] != '0) !== exp_vec(t)) begin
            failures++; $display("FAIL timeout t=%0d got=%h exp=%h", t, obs_vec(e_req[t] != '0), exp_vec(t));
         end
      end
      rd_ack = 1'b0;
      test_zero_mask();
   endtask

   task automatic test_reset_mid();
      int caps;
      for (int i = 0; i < MAXT; i++) ack_bits[i] = 1'b1;
      build_model(10'h011, 2, 8, 1);
      @(negedge lvds_clk);
      ch_mask = 10'h011; settle_cyc = 16'd2; cap_len = 8'd8; words_per_ch = 8'd1; start = 1'b1;
      caps = 0;
      for (int t = 1; t < e_len; t++) begin
         @(negedge lvds_clk);
         start = 1'b0;
         checks++;
         if (obs_vec(e_req[t] != '0) !== exp_vec(t)) begin
            failures++; $display("FAIL rst_mid_pre t=%0d got=%h exp=%h", t, obs_vec(e_req[t] != '0), exp_vec(t));
         end
         if (e_cap[t] != '0) caps++;
         if (caps == 3) break;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs_vec(1'b1) !== 28'd0) begin
         failures++; $display("FAIL rst_mid_async got=%h exp=0", obs_vec(1'b1));
      end
      @(negedge lvds_clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge lvds_clk);
         checks++;
         if (obs_vec(1'b1) !== 28'd0) begin
            failures++; $display("FAIL rst_mid_after got=%h exp=0", obs_vec(1'b1));
         end
      end
      test_basic();
   endtask

   task automatic test_random();
      logic [NCH-1:0] m;
      int st;
      int cl;
      int wpc;
      for (int it = 0; it < 25; it++) begin
         m   = ($urandom_range(0, 4) == 0) ? '0 : NCH'($urandom);
         st  = $urandom_range(0, 4);
         cl  = $urandom_range(0, 5);
         wpc = $urandom_range(0, 3);
         for (int i = 0; i < MAXT; i++) ack_bits[i] = ($urandom_range(0, 2) != 0);
         build_model(m, st, cl, wpc);
         @(negedge lvds_clk);
         ch_mask = m; settle_cyc = 16'(st); cap_len = 8'(cl); words_per_ch = 8'(wpc); start = 1'b1;
         for (int t = 1; t < e_len; t++) begin
            @(negedge lvds_clk);
            rd_ack = ack_bits[t];
            start  = (t < e_len - 1) && ($urandom_range(0, 7) == 0);
            ch_mask = NCH'($urandom); settle_cyc = 16'($urandom_range(0, 9));
            cap_len = 8'($urandom_range(0, 9)); words_per_ch = 8'($urandom_range(0, 9));
            checks++;
            if (obs_vec(e_req[t] != '0) !== exp_vec(t)) begin
               failures++; $display("FAIL random it=%0d t=%0d got=%h exp=%h", it, t,
                                    obs_vec(e_req[t] != '0), exp_vec(t));
            end
         end
         start = 1'b0; rd_ack = 1'b0;
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; rd_ack = 1'b0;
      ch_mask = '0; settle_cyc = '0; cap_len = '0; words_per_ch = '0;
      test_reset();
      test_basic();
      test_zero_mask();
      test_abort();
      test_ignore();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
